// File: rtl/wordle_pkg.sv
// Shared definitions for the Wordle engine: feedback codes, state encodings
// and the helper that locates a letter inside a packed word.
package wordle_pkg;

    localparam logic [1:0] FB_GRAY   = 2'b00;
    localparam logic [1:0] FB_YELLOW = 2'b01;
    localparam logic [1:0] FB_GREEN  = 2'b10;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_ENTRY,
        ST_SCORE,
        ST_DONE
    } game_state_t;

    typedef enum logic [1:0] {
        SC_IDLE,
        SC_GREEN,
        SC_YELLOW
    } score_phase_t;

    // Position 0 lives in the MSBs, so letter idx starts this many bits up.
    function automatic int letter_lsb(input int idx, input int word_len, input int letter_w);
        return (word_len - 1 - idx) * letter_w;
    endfunction

endpackage

// File: rtl/wordle_score_unit.sv
// Two-pass sequential scorer: one letter per cycle for the green pass, then
// one letter per cycle for the duplicate-aware yellow pass.
module wordle_score_unit
    import wordle_pkg::*;
#(
    parameter int WORD_LEN = 5,
    parameter int LETTER_W = 8
) (
    input  logic                         Clk,
    input  logic                         reset,
    input  logic                         go,
    input  logic [WORD_LEN*LETTER_W-1:0] guess,
    input  logic [WORD_LEN*LETTER_W-1:0] secret,
    output logic [2*WORD_LEN-1:0]        fb,
    output logic                         done
);

    localparam int IDX_W = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_LEN - 1);

    logic [LETTER_W-1:0]   guess_let  [WORD_LEN];
    logic [LETTER_W-1:0]   secret_let [WORD_LEN];
    score_phase_t          phase_reg;
    logic [IDX_W-1:0]      idx_reg;
    logic [WORD_LEN-1:0]   green_reg;
    logic [WORD_LEN-1:0]   used_reg;
    logic [WORD_LEN-1:0]   yellow_reg;
    logic [WORD_LEN-1:0]   yellow_next;
    logic [WORD_LEN-1:0]   cand;
    logic [WORD_LEN-1:0]   take;
    logic [2*WORD_LEN-1:0] fb_next;
    logic [2*WORD_LEN-1:0] fb_reg;
    logic                  done_reg;
    logic                  found;
    logic                  cur_green;
    logic                  cur_match;
    logic [LETTER_W-1:0]   cur_letter;

    generate
        for (genvar gi = 0; gi < WORD_LEN; gi++) begin : g_slot
            assign guess_let[gi]  = guess[letter_lsb(gi, WORD_LEN, LETTER_W) +: LETTER_W];
            assign secret_let[gi] = secret[letter_lsb(gi, WORD_LEN, LETTER_W) +: LETTER_W];
            // A secret letter can still be claimed only if neither a green nor an earlier yellow took it.
            assign cand[gi] = !used_reg[gi] && !green_reg[gi] && (secret_let[gi] == cur_letter);
            assign fb_next[2*(WORD_LEN-1-gi) +: 2] = green_reg[gi]   ? FB_GREEN  :
                                                     yellow_next[gi] ? FB_YELLOW : FB_GRAY;
        end
    endgenerate

    assign cur_letter = guess_let[idx_reg];
    assign cur_green  = green_reg[idx_reg];
    assign cur_match  = (guess_let[idx_reg] == secret_let[idx_reg]);

    always_comb begin
        take        = '0;
        found       = 1'b0;
        yellow_next = yellow_reg;
        if (phase_reg == SC_YELLOW && !cur_green) begin
            for (int j = 0; j < WORD_LEN; j++) begin
                if (!found && cand[j]) begin
                    take[j] = 1'b1;
                    found   = 1'b1;
                end
            end
        end
        if (phase_reg == SC_YELLOW) begin
            yellow_next[idx_reg] = found;
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            phase_reg  <= SC_IDLE;
            idx_reg    <= '0;
            green_reg  <= '0;
            used_reg   <= '0;
            yellow_reg <= '0;
            fb_reg     <= '0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (phase_reg)
                SC_IDLE: begin
                    if (go) begin
                        phase_reg  <= SC_GREEN;
                        idx_reg    <= '0;
                        green_reg  <= '0;
                        used_reg   <= '0;
                        yellow_reg <= '0;
                    end
                end
                SC_GREEN: begin
                    green_reg[idx_reg] <= cur_match;
                    used_reg[idx_reg]  <= cur_match;
                    if (idx_reg == LAST_IDX) begin
                        idx_reg   <= '0;
                        phase_reg <= SC_YELLOW;
                    end else begin
                        idx_reg <= idx_reg + IDX_W'(1);
                    end
                end
                SC_YELLOW: begin
                    used_reg   <= used_reg | take;
                    yellow_reg <= yellow_next;
                    if (idx_reg == LAST_IDX) begin
                        idx_reg   <= '0;
                        phase_reg <= SC_IDLE;
                        fb_reg    <= fb_next;
                        done_reg  <= 1'b1;
                    end else begin
                        idx_reg <= idx_reg + IDX_W'(1);
                    end
                end
                default: phase_reg <= SC_IDLE;
            endcase
        end
    end

    assign fb   = fb_reg;
    assign done = done_reg;

endmodule

// File: rtl/wordle_engine.sv
// Wordle game engine: latches the secret, gathers guess letters, hands full
// guesses to the scorer and tracks win/lose over the allowed guesses.
module wordle_engine
    import wordle_pkg::*;
#(
    parameter int WORD_LEN    = 5,
    parameter int MAX_GUESSES = 6,
    parameter int LETTER_W    = 8
) (
    input  logic                               Clk,
    input  logic                               reset,
    input  logic                               Start,
    input  logic                               Ack,
    input  logic [WORD_LEN*LETTER_W-1:0]       secret,
    input  logic [LETTER_W-1:0]                letter_in,
    input  logic                               letter_valid,
    input  logic                               backspace,
    input  logic                               submit,
    output logic                               ready,
    output logic [$clog2(WORD_LEN+1)-1:0]      letter_cnt,
    output logic [3:0]                         guess_cnt,
    output logic [WORD_LEN*LETTER_W-1:0]       guess,
    output logic [2*WORD_LEN-1:0]              fb,
    output logic                               fb_valid,
    output logic                               reject,
    output logic                               win,
    output logic                               lose,
    output logic                               q_I,
    output logic                               q_Entry,
    output logic                               q_Score,
    output logic                               q_Done
);

    localparam int CNT_W = $clog2(WORD_LEN + 1);
    localparam logic [CNT_W-1:0]      FULL_CNT  = CNT_W'(WORD_LEN);
    localparam logic [3:0]            MAX_CNT   = 4'(MAX_GUESSES);
    localparam logic [2*WORD_LEN-1:0] ALL_GREEN = {WORD_LEN{FB_GREEN}};

    game_state_t                  state_reg;
    logic [LETTER_W-1:0]          guess_mem [WORD_LEN];
    logic [WORD_LEN*LETTER_W-1:0] guess_bus;
    logic [WORD_LEN*LETTER_W-1:0] secret_reg;
    logic [CNT_W-1:0]             letter_cnt_reg;
    logic [3:0]                   guess_cnt_reg;
    logic [2*WORD_LEN-1:0]        fb_reg;
    logic                         fb_valid_reg;
    logic                         reject_reg;
    logic                         win_reg;
    logic                         lose_reg;
    logic                         guess_full;
    logic                         score_go;
    logic                         score_done;
    logic [2*WORD_LEN-1:0]        score_fb;

    generate
        for (genvar gi = 0; gi < WORD_LEN; gi++) begin : g_pack
            assign guess_bus[letter_lsb(gi, WORD_LEN, LETTER_W) +: LETTER_W] = guess_mem[gi];
        end
    endgenerate

    assign guess_full = (letter_cnt_reg == FULL_CNT);
    // The guess buffer is frozen while scoring, so the scorer reads it live.
    assign score_go   = (state_reg == ST_ENTRY) && submit && guess_full;

    wordle_score_unit #(
        .WORD_LEN (WORD_LEN),
        .LETTER_W (LETTER_W)
    ) u_score (
        .Clk    (Clk),
        .reset  (reset),
        .go     (score_go),
        .guess  (guess_bus),
        .secret (secret_reg),
        .fb     (score_fb),
        .done   (score_done)
    );

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_INIT;
            secret_reg     <= '0;
            letter_cnt_reg <= '0;
            guess_cnt_reg  <= '0;
            fb_reg         <= '0;
            fb_valid_reg   <= 1'b0;
            reject_reg     <= 1'b0;
            win_reg        <= 1'b0;
            lose_reg       <= 1'b0;
            for (int i = 0; i < WORD_LEN; i++) guess_mem[i] <= '0;
        end else begin
            fb_valid_reg <= 1'b0;
            reject_reg   <= 1'b0;
            case (state_reg)
                ST_INIT: begin
                    if (Start) begin
                        secret_reg     <= secret;
                        letter_cnt_reg <= '0;
                        guess_cnt_reg  <= '0;
                        fb_reg         <= '0;
                        win_reg        <= 1'b0;
                        lose_reg       <= 1'b0;
                        for (int i = 0; i < WORD_LEN; i++) guess_mem[i] <= '0;
                        state_reg      <= ST_ENTRY;
                    end
                end
                ST_ENTRY: begin
                    if (submit) begin
                        if (guess_full) state_reg <= ST_SCORE;
                        else            reject_reg <= 1'b1;
                    end else if (backspace) begin
                        if (letter_cnt_reg != '0) begin
                            guess_mem[letter_cnt_reg - CNT_W'(1)] <= '0;
                            letter_cnt_reg <= letter_cnt_reg - CNT_W'(1);
                        end
                    end else if (letter_valid && !guess_full) begin
                        guess_mem[letter_cnt_reg] <= letter_in;
                        letter_cnt_reg <= letter_cnt_reg + CNT_W'(1);
                    end
                end
                ST_SCORE: begin
                    if (score_done) begin
                        fb_reg        <= score_fb;
                        fb_valid_reg  <= 1'b1;
                        guess_cnt_reg <= guess_cnt_reg + 4'd1;
                        if (score_fb == ALL_GREEN) begin
                            win_reg   <= 1'b1;
                            state_reg <= ST_DONE;
                        end else if (guess_cnt_reg + 4'd1 == MAX_CNT) begin
                            lose_reg  <= 1'b1;
                            state_reg <= ST_DONE;
                        end else begin
                            letter_cnt_reg <= '0;
                            for (int i = 0; i < WORD_LEN; i++) guess_mem[i] <= '0;
                            state_reg <= ST_ENTRY;
                        end
                    end
                end
                ST_DONE: begin
                    if (Ack) begin
                        win_reg   <= 1'b0;
                        lose_reg  <= 1'b0;
                        state_reg <= ST_INIT;
                    end
                end
                default: state_reg <= ST_INIT;
            endcase
        end
    end

    assign q_I        = (state_reg == ST_INIT);
    assign q_Entry    = (state_reg == ST_ENTRY);
    assign q_Score    = (state_reg == ST_SCORE);
    assign q_Done     = (state_reg == ST_DONE);
    assign ready      = q_Entry;
    assign letter_cnt = letter_cnt_reg;
    assign guess_cnt  = guess_cnt_reg;
    assign guess      = guess_bus;
    assign fb         = fb_reg;
    assign fb_valid   = fb_valid_reg;
    assign reject     = reject_reg;
    assign win        = win_reg;
    assign lose       = lose_reg;

endmodule

// File: tb/tb_wordle_engine.sv
// Bench for wordle_engine: a letter-count Wordle model checked every cycle,
// plus hand-computed feedback and latency expectations for directed games.
module tb_wordle_engine;

    localparam int N    = 5;
    localparam int W    = 8;
    localparam int MAXG = 6;

    logic           Clk = 1'b0;
    logic           reset = 1'b1;
    logic           Start = 1'b0;
    logic           Ack = 1'b0;
    logic [N*W-1:0] secret = '0;
    logic [W-1:0]   letter_in = '0;
    logic           letter_valid = 1'b0;
    logic           backspace = 1'b0;
    logic           submit = 1'b0;
    logic           ready;
    logic [$clog2(N+1)-1:0] letter_cnt;
    logic [3:0]     guess_cnt;
    logic [N*W-1:0] guess;
    logic [2*N-1:0] fb;
    logic           fb_valid, reject, win, lose;
    logic           q_I, q_Entry, q_Score, q_Done;

    always #5 Clk = ~Clk;

    wordle_engine #(.WORD_LEN(N), .MAX_GUESSES(MAXG), .LETTER_W(W)) dut (
        .Clk(Clk), .reset(reset), .Start(Start), .Ack(Ack), .secret(secret),
        .letter_in(letter_in), .letter_valid(letter_valid), .backspace(backspace),
        .submit(submit), .ready(ready), .letter_cnt(letter_cnt), .guess_cnt(guess_cnt),
        .guess(guess), .fb(fb), .fb_valid(fb_valid), .reject(reject), .win(win),
        .lose(lose), .q_I(q_I), .q_Entry(q_Entry), .q_Score(q_Score), .q_Done(q_Done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural game model ----------------
    // m_state: 0 init, 1 entry, 2 scoring, 3 done
    int             m_state = 0;
    byte unsigned   m_sec [N];
    byte unsigned   m_gs  [N];
    int             m_cnt = 0, m_gcnt = 0, m_timer = 0;
    logic [2*N-1:0] m_fb = '0, m_pending = '0;
    bit             m_fbv = 0, m_rej = 0, m_win = 0, m_lose = 0;

    // Standard Wordle rule: greens first, then yellows drawn from the pool
    // of secret letters that were not matched green.
    function automatic logic [2*N-1:0] model_score();
        int         avail [256];
        logic [1:0] code  [N];
        logic [2*N-1:0] r;
        foreach (avail[k]) avail[k] = 0;
        for (int i = 0; i < N; i++) begin
            if (m_gs[i] == m_sec[i]) code[i] = 2'b10;
            else begin
                code[i] = 2'b00;
                avail[m_sec[i]]++;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (code[i] != 2'b10 && avail[m_gs[i]] > 0) begin
                code[i] = 2'b01;
                avail[m_gs[i]]--;
            end
        end
        r = '0;
        for (int i = 0; i < N; i++) r = (r << 2) | {{(2*N-2){1'b0}}, code[i]};
        return r;
    endfunction

    function automatic logic [63:0] model_guess();
        logic [63:0] v = '0;
        for (int i = 0; i < N; i++) v = (v << 8) | 64'(m_gs[i]);
        return v;
    endfunction

    task automatic model_clear_guess();
        for (int i = 0; i < N; i++) m_gs[i] = 8'h00;
        m_cnt = 0;
    endtask

    task automatic model_step();
        if (reset) begin
            m_state = 0; m_gcnt = 0; m_fb = '0; m_fbv = 0; m_rej = 0;
            m_win = 0; m_lose = 0; m_timer = 0;
            model_clear_guess();
        end else begin
            m_fbv = 0;
            m_rej = 0;
            case (m_state)
                0: if (Start) begin
                    for (int i = 0; i < N; i++) m_sec[i] = secret[(N-1-i)*W +: W];
                    model_clear_guess();
                    m_gcnt = 0; m_fb = '0; m_win = 0; m_lose = 0;
                    m_state = 1;
                end
                1: begin
                    if (submit) begin
                        if (m_cnt == N) begin
                            m_pending = model_score();
                            m_timer   = 2*N + 1;
                            m_state   = 2;
                        end else m_rej = 1;
                    end else if (backspace) begin
                        if (m_cnt > 0) begin
                            m_cnt--;
                            m_gs[m_cnt] = 8'h00;
                        end
                    end else if (letter_valid && m_cnt < N) begin
                        m_gs[m_cnt] = letter_in;
                        m_cnt++;
                    end
                end
                2: begin
                    m_timer--;
                    if (m_timer == 0) begin
                        m_fb = m_pending;
                        m_fbv = 1;
                        m_gcnt++;
                        if (m_pending == {N{2'b10}}) begin
                            m_win = 1; m_state = 3;
                        end else if (m_gcnt == MAXG) begin
                            m_lose = 1; m_state = 3;
                        end else begin
                            model_clear_guess();
                            m_state = 1;
                        end
                    end
                end
                default: if (Ack) begin
                    m_win = 0; m_lose = 0; m_state = 0;
                end
            endcase
        end
    endtask

    initial forever begin
        @(posedge Clk or posedge reset);
        model_step();
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge Clk);
        chk("ready",      ready,      m_state == 1);
        chk("q_I",        q_I,        m_state == 0);
        chk("q_Entry",    q_Entry,    m_state == 1);
        chk("q_Score",    q_Score,    m_state == 2);
        chk("q_Done",     q_Done,     m_state == 3);
        chk("letter_cnt", letter_cnt, m_cnt);
        chk("guess",      guess,      model_guess());
        chk("guess_cnt",  guess_cnt,  m_gcnt);
        chk("fb",         fb,         m_fb);
        chk("fb_valid",   fb_valid,   m_fbv);
        chk("reject",     reject,     m_rej);
        if (m_state == 3) begin
            chk("win",  win,  m_win);
            chk("lose", lose, m_lose);
        end
        if (fb_valid)
            $display("scored guess %0d: fb=%03h win=%0b lose=%0b", guess_cnt, fb, win, lose);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic pulse_start();
        Start = 1'b1; tick(); Start = 1'b0;
    endtask

    task automatic pulse_ack();
        Ack = 1'b1; tick(); Ack = 1'b0;
    endtask

    task automatic type_letter(input logic [W-1:0] c);
        letter_in = c; letter_valid = 1'b1; tick(); letter_valid = 1'b0;
    endtask

    task automatic type_word(input logic [N*W-1:0] w);
        for (int i = 0; i < N; i++) type_letter(w[(N-1-i)*W +: W]);
    endtask

    task automatic wait_fb(output int n);
        n = 0;
        while (fb_valid !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        if (n >= 60) chk("fb_valid_timeout", fb_valid, 1);
    endtask

    task automatic submit_and_wait(output int n);
        submit = 1'b1; tick(); submit = 1'b0;
        wait_fb(n);
    endtask

    int  lat;
    bit  saw_fbv;

    initial begin
        repeat (3) tick();
        chk("rst_q_I", q_I, 1);
        chk("rst_ready", ready, 0);
        chk("rst_fb", fb, 0);
        chk("rst_guess_cnt", guess_cnt, 0);
        chk("rst_letter_cnt", letter_cnt, 0);
        chk("rst_win_lose", {win, lose, fb_valid, reject}, 0);
        reset = 1'b0;
        tick();

        // Game 1: immediate win, latency check
        secret = "CRIMP";
        pulse_start();
        secret = "ZZZZZ";
        type_word("CRIMP");
        submit_and_wait(lat);
        chk("crimp_latency", lat, 11);
        chk("crimp_fb", fb, 10'h2AA);
        chk("crimp_win", win, 1);
        chk("crimp_guess_cnt", guess_cnt, 1);
        chk("crimp_q_Done", q_Done, 1);
        tick();
        pulse_start();
        chk("start_in_done", q_Done, 1);
        pulse_ack();
        chk("ack_to_init", q_I, 1);

        // Game 2: duplicates, reject/backspace, then lose on the 6th guess
        secret = "ROBOT";
        pulse_start();
        type_word("BOOST");
        submit_and_wait(lat);
        chk("boost_fb", fb, 10'h192);
        chk("boost_q_Entry", q_Entry, 1);
        chk("boost_guess_cnt", guess_cnt, 1);
        type_letter("R"); type_letter("E"); type_letter("N"); type_letter("E");
        submit = 1'b1; tick(); submit = 1'b0;
        chk("rene_reject", reject, 1);
        chk("rene_q_Entry", q_Entry, 1);
        chk("rene_cnt", letter_cnt, 4);
        backspace = 1'b1; tick(); backspace = 1'b0;
        chk("bksp_cnt", letter_cnt, 3);
        type_letter("N"); type_letter("E"); type_letter("W");
        chk("full_cnt", letter_cnt, 5);
        chk("renne_buf", guess, "RENNE");
        submit_and_wait(lat);
        chk("renne_fb", fb, 10'h200);
        type_word("TOBOR");
        submit_and_wait(lat);
        chk("tobor_fb", fb, 10'h1A9);
        type_word("AAAAA");
        submit_and_wait(lat);
        type_word("XYZZY");
        submit_and_wait(lat);
        type_word("OBORT");
        submit_and_wait(lat);
        chk("obort_fb", fb, 10'h156);
        chk("lose_flag", lose, 1);
        chk("lose_win", win, 0);
        chk("lose_guess_cnt", guess_cnt, 6);
        tick();
        pulse_start();
        chk("lose_start_ignored", q_Done, 1);
        pulse_ack();

        // Game 3: extra duplicates, inputs during scoring, secret change ignored
        secret = "ABBOT";
        pulse_start();
        secret = "BBBBB";
        type_word("BBBBB");
        submit = 1'b1; tick();
        letter_in = "Q"; letter_valid = 1'b1; backspace = 1'b1; Ack = 1'b1; Start = 1'b1;
        tick(); tick();
        submit = 1'b0; letter_valid = 1'b0; backspace = 1'b0; Ack = 1'b0; Start = 1'b0;
        wait_fb(lat);
        chk("bbbbb_latency", lat + 2, 11);
        chk("bbbbb_fb", fb, 10'h0A0);
        chk("bbbbb_cnt", letter_cnt, 0);

        // Reset three cycles into scoring
        type_word("OBBAT");
        submit = 1'b1; tick(); submit = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        #1;
        chk("mid_rst_q_I", q_I, 1);
        chk("mid_rst_outs", {ready, fb_valid, reject, win, lose, q_Score}, 0);
        chk("mid_rst_fb", fb, 0);
        chk("mid_rst_guess", guess, 0);
        chk("mid_rst_cnts", {guess_cnt, 1'b0, letter_cnt}, 0);
        tick();
        reset = 1'b0;
        saw_fbv = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (fb_valid) saw_fbv = 1;
        end
        chk("no_fb_after_reset", saw_fbv, 0);
        chk("idle_after_reset", q_I, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
